// File: rtl/jpeg_block_sequencer_if.sv
// rtl/jpeg_block_sequencer_if.sv - address/handshake bundle between the block sequencer and its DCT/quantizer consumers
interface jpeg_block_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] frm_addr;
    logic              frm_vld;
    logic              frm_rdy;
    logic [5:0]        tr_addr;
    logic              tr_vld;
    logic              tr_rdy;
    logic [5:0]        zz_addr;
    logic              zz_vld;
    logic              zz_rdy;
    logic              stage_done;

    modport master (
        output frm_addr, frm_vld, tr_addr, tr_vld, zz_addr, zz_vld,
        input  frm_rdy, tr_rdy, zz_rdy, stage_done
    );

    modport slave (
        input  frm_addr, frm_vld, tr_addr, tr_vld, zz_addr, zz_vld,
        output frm_rdy, tr_rdy, zz_rdy, stage_done
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// rtl/jpeg_block_sequencer.sv - 8x8 block ROW/COL/ZIG address sequencer for the MJPEG encode path
// Optional SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module jpeg_block_sequencer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 16,
    localparam int NBX  = IMG_W / 8,
    localparam int NBY  = IMG_H / 8,
    localparam int BX_W = (NBX > 1) ? $clog2(NBX) : 1,
    localparam int BY_W = (NBY > 1) ? $clog2(NBY) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    jpeg_block_sequencer_if.master bus,
    output logic [BX_W-1:0]       blk_x,
    output logic [BY_W-1:0]       blk_y,
    output logic                  busy,
    output logic                  blk_done,
    output logic                  frame_done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam longint unsigned NPIX = longint'(IMG_W) * longint'(IMG_H);

    if (IMG_W % 8 != 0 || IMG_W < 8) begin : g_bad_img_w
        $error("IMG_W must be a non-zero multiple of 8");
    end
    if (IMG_H % 8 != 0 || IMG_H < 8) begin : g_bad_img_h
        $error("IMG_H must be a non-zero multiple of 8");
    end
    if (ADDR_W < 1 || (ADDR_W < 63 && (64'd1 << ADDR_W) < NPIX)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for IMG_W*IMG_H pixels");
    end

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 7);
    localparam logic [ADDR_W-1:0] BLK_STEP = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ROW_JUMP = ADDR_W'(8 + 7 * IMG_W);
    localparam logic [BX_W-1:0]   BX_MAX   = BX_W'(NBX - 1);
    localparam logic [BY_W-1:0]   BY_MAX   = BY_W'(NBY - 1);

    // Natural (row-major) coefficient index for each zigzag position.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [2:0] {IDLE, ROW, ROW_W, COL, COL_W, ZIG, ZIG_W, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [5:0]        k;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] frm_addr_q;
    logic              beat;
    logic              last_blk;

    assign last_blk     = (blk_x == BX_MAX) && (blk_y == BY_MAX);
    assign bus.frm_addr = frm_addr_q;
    assign bus.tr_addr  = {k[2:0], k[5:3]};
    assign bus.zz_addr  = ZZ[k];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        blk_done    = 1'b0;
        frame_done  = 1'b0;
        busy        = (state != IDLE);
        bus.frm_vld = (state == ROW);
        bus.tr_vld  = (state == COL);
        bus.zz_vld  = (state == ZIG);
        beat        = (bus.frm_vld && bus.frm_rdy) || (bus.tr_vld && bus.tr_rdy) ||
                      (bus.zz_vld && bus.zz_rdy);
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state_next = ROW;
                ROW:   if (beat && k == 6'd63) state_next = ROW_W;
                ROW_W: if (bus.stage_done) state_next = COL;
                COL:   if (beat && k == 6'd63) state_next = COL_W;
                COL_W: if (bus.stage_done) state_next = ZIG;
                ZIG:   if (beat && k == 6'd63) state_next = ZIG_W;
                ZIG_W: begin
                    if (bus.stage_done) begin
                        blk_done   = 1'b1;
                        state_next = last_blk ? DONE : ROW;
                    end
                end
                DONE: begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // k wraps 63 -> 0 on the final beat, so every phase starts from k=0 without extra clears.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            k          <= '0;
            base       <= '0;
            frm_addr_q <= '0;
            blk_x      <= '0;
            blk_y      <= '0;
        end else begin
            if (beat) k <= k + 6'd1;
            if (state == ROW && beat && k != 6'd63)
                frm_addr_q <= frm_addr_q + ((k[2:0] == 3'd7) ? ROW_STEP : ADDR_W'(1));
            if (blk_done) begin
                if (last_blk) begin
                    base       <= '0;
                    frm_addr_q <= '0;
                    blk_x      <= '0;
                    blk_y      <= '0;
                end else if (blk_x == BX_MAX) begin
                    blk_x      <= '0;
                    blk_y      <= blk_y + BY_W'(1);
                    base       <= base + ROW_JUMP;
                    frm_addr_q <= base + ROW_JUMP;
                end else begin
                    blk_x      <= blk_x + BX_W'(1);
                    base       <= base + BLK_STEP;
                    frm_addr_q <= base + BLK_STEP;
                end
            end
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic stall;
    assign stall = (bus.frm_vld && !bus.frm_rdy) || (bus.tr_vld && !bus.tr_rdy) ||
                   (bus.zz_vld && !bus.zz_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == IDLE && start && !abort)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
